// File: rtl/pipe_id_ctrl_pkg.sv
// pipe_id_ctrl_pkg
//   Shared definitions for the ID-stage controller. It holds the MIPS opcode and
//   funct constants, the ALU operation codes driven to EXE, the operand-forwarding
//   select encodings, and a decode helper that maps (opcode, funct) to the
//   control bundle used by the ID stage.
//   This package has no ports.
package pipe_id_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    // The don't-care top bit of the non-shift codes is driven as 0.
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXE   = 2'd1,
        FWD_MEM   = 2'd2,
        FWD_MEMLD = 2'd3
    } fwd_t;

    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic       jal;
        logic       aluimm;
        logic       shift;
        logic       sext;
        logic       uses_rs;
        logic       uses_rt;
        logic [3:0] aluc;
    } dec_t;

    // Unknown opcodes/functs fall through with every write control at 0 (NOP).
    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d      = '0;
        d.aluc = ALUC_ADD;
        d.sext = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD: begin d.wreg = 1'b1; d.uses_rs = 1'b1; d.uses_rt = 1'b1; end
                    FN_SUB: begin d.wreg = 1'b1; d.uses_rs = 1'b1; d.uses_rt = 1'b1; d.aluc = ALUC_SUB; end
                    FN_AND: begin d.wreg = 1'b1; d.uses_rs = 1'b1; d.uses_rt = 1'b1; d.aluc = ALUC_AND; end
                    FN_OR:  begin d.wreg = 1'b1; d.uses_rs = 1'b1; d.uses_rt = 1'b1; d.aluc = ALUC_OR;  end
                    FN_XOR: begin d.wreg = 1'b1; d.uses_rs = 1'b1; d.uses_rt = 1'b1; d.aluc = ALUC_XOR; end
                    // Shifts read only rt; the amount comes from shamt.
                    FN_SLL: begin d.wreg = 1'b1; d.uses_rt = 1'b1; d.shift = 1'b1; d.aluc = ALUC_SLL; end
                    FN_SRL: begin d.wreg = 1'b1; d.uses_rt = 1'b1; d.shift = 1'b1; d.aluc = ALUC_SRL; end
                    FN_SRA: begin d.wreg = 1'b1; d.uses_rt = 1'b1; d.shift = 1'b1; d.aluc = ALUC_SRA; end
                    FN_JR:  begin d.uses_rs = 1'b1; end
                    default: ;
                endcase
            end
            OP_ADDI: begin d.wreg = 1'b1; d.aluimm = 1'b1; d.uses_rs = 1'b1; end
            OP_ANDI: begin d.wreg = 1'b1; d.aluimm = 1'b1; d.uses_rs = 1'b1; d.sext = 1'b0; d.aluc = ALUC_AND; end
            OP_ORI:  begin d.wreg = 1'b1; d.aluimm = 1'b1; d.uses_rs = 1'b1; d.sext = 1'b0; d.aluc = ALUC_OR;  end
            OP_XORI: begin d.wreg = 1'b1; d.aluimm = 1'b1; d.uses_rs = 1'b1; d.sext = 1'b0; d.aluc = ALUC_XOR; end
            OP_LUI:  begin d.wreg = 1'b1; d.aluimm = 1'b1; d.aluc = ALUC_LUI; end
            OP_LW:   begin d.wreg = 1'b1; d.m2reg = 1'b1; d.aluimm = 1'b1; d.uses_rs = 1'b1; end
            OP_SW:   begin d.wmem = 1'b1; d.aluimm = 1'b1; d.uses_rs = 1'b1; d.uses_rt = 1'b1; end
            OP_BEQ:  begin d.uses_rs = 1'b1; d.uses_rt = 1'b1; d.aluc = ALUC_SUB; end
            OP_BNE:  begin d.uses_rs = 1'b1; d.uses_rt = 1'b1; d.aluc = ALUC_SUB; end
            OP_JAL:  begin d.wreg = 1'b1; d.jal = 1'b1; end
            OP_J:    ;
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pipe_id_ctrl_fwd_sel.sv
// pipe_fwd_sel
//   Forwarding select for one source operand. EXE wins over MEM; register 0 never
//   forwards; a load still in EXE cannot forward (that case is a stall instead).
// Ports
//   src       in  RW  source register number being read in ID
//   ern       in  RW  EXE destination register
//   ewreg_i   in  1   EXE writes a register
//   em2reg_i  in  1   EXE is a load
//   mrn       in  RW  MEM destination register
//   mwreg     in  1   MEM writes a register
//   mm2reg    in  1   MEM is a load
//   sel       out 2   fwd_t encoding: RF, EXE, MEM (ALU) or MEMLD (load data)
module pipe_fwd_sel
    import pipe_id_ctrl_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic [RW-1:0] src,
    input  logic [RW-1:0] ern,
    input  logic          ewreg_i,
    input  logic          em2reg_i,
    input  logic [RW-1:0] mrn,
    input  logic          mwreg,
    input  logic          mm2reg,
    output logic [1:0]    sel
);

    always_comb begin
        sel = FWD_RF;
        if (ewreg_i && !em2reg_i && (ern != '0) && (ern == src)) begin
            sel = FWD_EXE;
        end else if (mwreg && (mrn != '0) && (mrn == src)) begin
            sel = mm2reg ? FWD_MEMLD : FWD_MEM;
        end
    end

endmodule

// File: rtl/pipe_id_ctrl.sv
// pipe_id_ctrl
//   ID-stage control plus the ID/EXE pipeline register. Decodes the instruction,
//   selects forwarded operands, detects load-use hazards (stall + bubble) and
//   counts stall cycles with a saturating counter.
// Ports
//   clk, clrn                 clock (rising edge), synchronous active-low reset
//   dinst, dpc4               instruction in ID and its PC+4
//   qa, qb                    register-file read data for rs, rt
//   ealu, malu, mmo           forwarding sources (EXE result, MEM ALU, MEM load)
//   ern, ewreg_i, em2reg_i    current EXE destination and controls
//   mrn, mwreg, mm2reg        current MEM destination and controls
//   wpcir                     PC / IF-ID write enable, 0 while stalling
//   ewreg..eshift, ealuc      registered EXE controls
//   ea, eb, eimm, epc4, ern0  registered EXE data and destination
//   stall_cnt                 load-use stall cycles since reset (saturating)
module pipe_id_ctrl
    import pipe_id_ctrl_pkg::*;
#(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [31:0]      dinst,
    input  logic [DW-1:0]    dpc4,
    input  logic [DW-1:0]    qa,
    input  logic [DW-1:0]    qb,
    input  logic [DW-1:0]    ealu,
    input  logic [DW-1:0]    malu,
    input  logic [DW-1:0]    mmo,
    input  logic [RW-1:0]    ern,
    input  logic             ewreg_i,
    input  logic             em2reg_i,
    input  logic [RW-1:0]    mrn,
    input  logic             mwreg,
    input  logic             mm2reg,
    output logic             wpcir,
    output logic             ewreg,
    output logic             em2reg,
    output logic             ewmem,
    output logic             ejal,
    output logic             ealuimm,
    output logic             eshift,
    output logic [3:0]       ealuc,
    output logic [DW-1:0]    ea,
    output logic [DW-1:0]    eb,
    output logic [DW-1:0]    eimm,
    output logic [DW-1:0]    epc4,
    output logic [RW-1:0]    ern0,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [5:0]    op;
    logic [5:0]    fn;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [4:0]    sa;
    logic [15:0]   imm;
    dec_t          dec;
    logic          stall;
    logic [1:0]    sel_a;
    logic [1:0]    sel_b;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
    logic [DW-1:0] imm_ext;
    logic [RW-1:0] rn;

    assign op  = dinst[31:26];
    assign rs  = dinst[25:21];
    assign rt  = dinst[20:16];
    assign rd  = dinst[15:11];
    assign sa  = dinst[10:6];
    assign fn  = dinst[5:0];
    assign imm = dinst[15:0];
    assign dec = decode(op, fn);

    // Only a load in EXE stalls: its data is not available until MEM.
    assign stall = ewreg_i & em2reg_i & (ern != '0) &
                   ((dec.uses_rs & (ern == rs)) | (dec.uses_rt & (ern == rt)));
    assign wpcir = ~stall;

    pipe_fwd_sel #(.RW(RW)) u_fwd_a (
        .src(rs), .ern(ern), .ewreg_i(ewreg_i), .em2reg_i(em2reg_i),
        .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .sel(sel_a)
    );

    pipe_fwd_sel #(.RW(RW)) u_fwd_b (
        .src(rt), .ern(ern), .ewreg_i(ewreg_i), .em2reg_i(em2reg_i),
        .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .sel(sel_b)
    );

    always_comb begin
        fwd_a = qa;
        case (sel_a)
            FWD_EXE:   fwd_a = ealu;
            FWD_MEM:   fwd_a = malu;
            FWD_MEMLD: fwd_a = mmo;
            default:   fwd_a = qa;
        endcase
        fwd_b = qb;
        case (sel_b)
            FWD_EXE:   fwd_b = ealu;
            FWD_MEM:   fwd_b = malu;
            FWD_MEMLD: fwd_b = mmo;
            default:   fwd_b = qb;
        endcase
    end

    // Shifts carry shamt in bits [10:6] so EXE can take the amount from eimm.
    always_comb begin
        imm_ext = '0;
        if (dec.shift) begin
            imm_ext[10:6] = sa;
        end else if (dec.sext) begin
            imm_ext = {{(DW-16){imm[15]}}, imm};
        end else begin
            imm_ext = {{(DW-16){1'b0}}, imm};
        end
    end

    // jal links into the all-ones register ($31).
    always_comb begin
        rn = rt;
        if (op == OP_RTYPE) begin
            rn = rd;
        end else if (dec.jal) begin
            rn = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            ewreg     <= 1'b0;
            em2reg    <= 1'b0;
            ewmem     <= 1'b0;
            ejal      <= 1'b0;
            ealuimm   <= 1'b0;
            eshift    <= 1'b0;
            ealuc     <= '0;
            ea        <= '0;
            eb        <= '0;
            eimm      <= '0;
            epc4      <= '0;
            ern0      <= '0;
            stall_cnt <= '0;
        end else begin
            // A stall turns the ID instruction into a bubble; data fields are don't-care.
            ewreg   <= dec.wreg  & ~stall;
            em2reg  <= dec.m2reg & ~stall;
            ewmem   <= dec.wmem  & ~stall;
            ejal    <= dec.jal   & ~stall;
            ealuimm <= dec.aluimm;
            eshift  <= dec.shift;
            ealuc   <= dec.aluc;
            ea      <= fwd_a;
            eb      <= fwd_b;
            eimm    <= imm_ext;
            epc4    <= dpc4;
            ern0    <= rn;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_id_ctrl.sv
module tb_pipe_id_ctrl;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CNT_W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  logic [31:0] dinst;
  logic [DW-1:0] dpc4, qa, qb, ealu, malu, mmo;
  logic [RW-1:0] ern, mrn;
  logic ewreg_i, em2reg_i, mwreg, mm2reg;
  logic wpcir, ewreg, em2reg, ewmem, ejal, ealuimm, eshift;
  logic [3:0] ealuc;
  logic [DW-1:0] ea, eb, eimm, epc4;
  logic [RW-1:0] ern0;
  logic [CNT_W-1:0] stall_cnt;

  pipe_id_ctrl #(.DW(DW), .RW(RW), .CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn), .dinst(dinst), .dpc4(dpc4), .qa(qa), .qb(qb),
    .ealu(ealu), .malu(malu), .mmo(mmo), .ern(ern), .ewreg_i(ewreg_i),
    .em2reg_i(em2reg_i), .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
    .wpcir(wpcir), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ejal(ejal),
    .ealuimm(ealuimm), .eshift(eshift), .ealuc(ealuc), .ea(ea), .eb(eb),
    .eimm(eimm), .epc4(epc4), .ern0(ern0), .stall_cnt(stall_cnt)
  );

  typedef enum int {
    M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA, M_JR,
    M_ADDI, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW, M_BEQ, M_BNE,
    M_J, M_JAL, M_BAD
  } mn_t;

  typedef struct packed {
    logic bub;
    logic wreg, m2reg, wmem, jal, aluimm, shift;
    logic [3:0] aluc;
    logic [31:0] a, b, imm, pc4;
    logic [4:0] rn;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int model_cnt = 0;

  // scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] encode(mn_t mn, logic [4:0] rs, logic [4:0] rt,
                                         logic [4:0] rd, logic [4:0] sa, logic [15:0] imm);
    case (mn)
      M_ADD:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      M_SUB:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      M_AND:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      M_OR:   return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      M_XOR:  return {6'h00, rs, rt, rd, 5'd0, 6'h26};
      M_SLL:  return {6'h00, rs, rt, rd, sa, 6'h00};
      M_SRL:  return {6'h00, rs, rt, rd, sa, 6'h02};
      M_SRA:  return {6'h00, rs, rt, rd, sa, 6'h03};
      M_JR:   return {6'h00, rs, 15'd0, 6'h08};
      M_ADDI: return {6'h08, rs, rt, imm};
      M_ANDI: return {6'h0c, rs, rt, imm};
      M_ORI:  return {6'h0d, rs, rt, imm};
      M_XORI: return {6'h0e, rs, rt, imm};
      M_LUI:  return {6'h0f, rs, rt, imm};
      M_LW:   return {6'h23, rs, rt, imm};
      M_SW:   return {6'h2b, rs, rt, imm};
      M_BEQ:  return {6'h04, rs, rt, imm};
      M_BNE:  return {6'h05, rs, rt, imm};
      M_J:    return {6'h02, rs, rt, imm};
      M_JAL:  return {6'h03, rs, rt, imm};
      default: return {6'h3f, rs, rt, imm};
    endcase
  endfunction

  function automatic logic [31:0] fwd_val(logic [4:0] src, logic [31:0] rf);
    if (ewreg_i && !em2reg_i && ern != 0 && ern == src) return ealu;
    if (mwreg && mrn != 0 && mrn == src) return mm2reg ? mmo : malu;
    return rf;
  endfunction

  function automatic bit stall_of(mn_t mn, logic [31:0] ins);
    bit use_rs, use_rt;
    use_rs = mn inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_JR, M_ADDI, M_ANDI,
                        M_ORI, M_XORI, M_LW, M_SW, M_BEQ, M_BNE};
    use_rt = mn inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA,
                        M_SW, M_BEQ, M_BNE};
    return ewreg_i && em2reg_i && ern != 0 &&
           ((use_rs && ern == ins[25:21]) || (use_rt && ern == ins[20:16]));
  endfunction

  function automatic exp_t model(mn_t mn, logic [31:0] ins);
    exp_t e;
    e = '0;
    e.wreg = mn inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA,
                        M_ADDI, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_JAL};
    e.m2reg = (mn == M_LW);
    e.wmem = (mn == M_SW);
    e.jal = (mn == M_JAL);
    e.aluimm = mn inside {M_ADDI, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW};
    e.shift = mn inside {M_SLL, M_SRL, M_SRA};
    case (mn)
      M_SUB, M_BEQ, M_BNE: e.aluc = 4'b0100;
      M_AND, M_ANDI:       e.aluc = 4'b0001;
      M_OR, M_ORI:         e.aluc = 4'b0101;
      M_XOR, M_XORI:       e.aluc = 4'b0010;
      M_LUI:               e.aluc = 4'b0110;
      M_SLL:               e.aluc = 4'b0011;
      M_SRL:               e.aluc = 4'b0111;
      M_SRA:               e.aluc = 4'b1111;
      default:             e.aluc = 4'b0000;
    endcase
    if (e.shift) e.imm = {21'd0, ins[10:6], 6'd0};
    else if (mn inside {M_ANDI, M_ORI, M_XORI}) e.imm = {16'd0, ins[15:0]};
    else e.imm = {{16{ins[15]}}, ins[15:0]};
    if (mn inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA, M_JR}) e.rn = ins[15:11];
    else if (mn == M_JAL) e.rn = 5'd31;
    else e.rn = ins[20:16];
    e.a = fwd_val(ins[25:21], qa);
    e.b = fwd_val(ins[20:16], qb);
    e.pc4 = dpc4;
    return e;
  endfunction

  // driver: present one instruction in ID for one clock and check the result
  task automatic step(input mn_t mn, input logic [31:0] ins);
    exp_t e, got;
    bit st;
    dinst = ins;
    #1;
    st = stall_of(mn, ins);
    check("wpcir", {31'd0, wpcir}, {31'd0, !st});
    e = model(mn, ins);
    if (!clrn) begin
      e = '0;
      model_cnt = 0;
    end else begin
      if (st) begin
        e.bub = 1'b1;
        e.wreg = 1'b0; e.m2reg = 1'b0; e.wmem = 1'b0; e.jal = 1'b0;
        if (model_cnt < (1 << CNT_W) - 1) model_cnt++;
      end
      e.cnt = model_cnt[CNT_W-1:0];
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("ewreg", {31'd0, ewreg}, {31'd0, got.wreg});
    check("em2reg", {31'd0, em2reg}, {31'd0, got.m2reg});
    check("ewmem", {31'd0, ewmem}, {31'd0, got.wmem});
    check("ejal", {31'd0, ejal}, {31'd0, got.jal});
    check("stall_cnt", {{(32-CNT_W){1'b0}}, stall_cnt}, {{(32-CNT_W){1'b0}}, got.cnt});
    if (!got.bub) begin
      check("ealuimm", {31'd0, ealuimm}, {31'd0, got.aluimm});
      check("eshift", {31'd0, eshift}, {31'd0, got.shift});
      check("ealuc", {28'd0, ealuc}, {28'd0, got.aluc});
      check("ea", ea, got.a);
      check("eb", eb, got.b);
      check("eimm", eimm, got.imm);
      check("epc4", epc4, got.pc4);
      check("ern0", {27'd0, ern0}, {27'd0, got.rn});
    end
  endtask

  task automatic quiet_env();
    qa = 0; qb = 0; ealu = 0; malu = 0; mmo = 0; dpc4 = 0;
    ern = 0; mrn = 0; ewreg_i = 0; em2reg_i = 0; mwreg = 0; mm2reg = 0;
  endtask

  task automatic rand_env();
    qa = $urandom; qb = $urandom; ealu = $urandom; malu = $urandom; mmo = $urandom;
    dpc4 = $urandom & 32'hffff_fffc;
    ern = 5'($urandom_range(0, 3)); mrn = 5'($urandom_range(0, 3));
    ewreg_i = 1'($urandom_range(0, 1)); em2reg_i = 1'($urandom_range(0, 1));
    mwreg = 1'($urandom_range(0, 1)); mm2reg = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mn_t mn;
    logic [31:0] ins;

    // reset: two cycles, second one with a load-use hazard present
    quiet_env();
    clrn = 1'b0;
    dinst = 32'd0;
    #1;
    check("rst_wpcir", {31'd0, wpcir}, 32'd1);
    step(M_SLL, 32'd0);
    ern = 5'd2; ewreg_i = 1'b1; em2reg_i = 1'b1;
    step(M_ADD, encode(M_ADD, 5'd2, 5'd2, 5'd4, 5'd0, 16'd0));
    check("rst_wins_cnt", {28'd0, stall_cnt}, 32'd0);
    clrn = 1'b1;

    // add $3,$1,$2 with no hazards
    quiet_env();
    qa = 32'd5; qb = 32'd7; dpc4 = 32'h40;
    step(M_ADD, encode(M_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0));
    check("t2_ea", ea, 32'd5);
    check("t2_eb", eb, 32'd7);
    check("t2_ern0", {27'd0, ern0}, 32'd3);

    // EXE beats MEM
    ern = 5'd1; ewreg_i = 1'b1; em2reg_i = 1'b0; ealu = 32'h10;
    mrn = 5'd1; mwreg = 1'b1; malu = 32'h20;
    step(M_ADD, encode(M_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0));
    check("t3_ea", ea, 32'h10);

    // load-use stall then release
    quiet_env();
    ern = 5'd2; ewreg_i = 1'b1; em2reg_i = 1'b1;
    step(M_ADD, encode(M_ADD, 5'd2, 5'd2, 5'd4, 5'd0, 16'd0));
    check("t4_bubble", {31'd0, ewreg}, 32'd0);
    check("t4_cnt", {28'd0, stall_cnt}, 32'd1);
    ewreg_i = 1'b0; em2reg_i = 1'b0;
    step(M_ADD, encode(M_ADD, 5'd2, 5'd2, 5'd4, 5'd0, 16'd0));
    check("t4_release", {31'd0, ewreg}, 32'd1);

    // register 0 never forwards or stalls
    ern = 5'd0; ewreg_i = 1'b1; em2reg_i = 1'b1; mrn = 5'd0; mwreg = 1'b1;
    qa = 32'h55;
    step(M_ADD, encode(M_ADD, 5'd0, 5'd0, 5'd6, 5'd0, 16'd0));
    check("t5_ea", ea, 32'h55);

    // zero- vs sign-extension
    quiet_env();
    step(M_ORI, encode(M_ORI, 5'd0, 5'd5, 5'd0, 5'd0, 16'h8000));
    check("t6_ori_imm", eimm, 32'h0000_8000);
    step(M_ADDI, encode(M_ADDI, 5'd0, 5'd5, 5'd0, 5'd0, 16'h8000));
    check("t6_addi_imm", eimm, 32'hffff_8000);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_env();
      mn = mn_t'($urandom_range(0, 20));
      ins = encode(mn, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom), 5'($urandom), 16'($urandom));
      step(mn, ins);
    end

    // counter saturation after a fresh reset
    quiet_env();
    clrn = 1'b0;
    step(M_SLL, 32'd0);
    clrn = 1'b1;
    ern = 5'd3; ewreg_i = 1'b1; em2reg_i = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step(M_SW, encode(M_SW, 5'd1, 5'd3, 5'd0, 5'd0, 16'($urandom)));
    end
    check("sat_cnt", {28'd0, stall_cnt}, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
